// File: rtl/ps2_key_decoder_if.sv
// PS/2 key decoder bus: raw PS/2 lines in, key_counter-facing outputs.
//   ps2_clk, ps2_data : raw PS/2 lines (asynchronous to the system clock)
//   key_press         : held counted key level
//   backspace         : held key is backspace
//   key_nibble        : last hex-digit value
//   nibble_valid      : one-cycle pulse on hex-digit make
//   enter_pulse       : one-cycle pulse on Enter make
//   frame_error       : one-cycle pulse on receive error
// master drives the PS/2 lines (keyboard side); slave is the decoder.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_press;
    logic       backspace;
    logic [3:0] key_nibble;
    logic       nibble_valid;
    logic       enter_pulse;
    logic       frame_error;

    modport master (
        output ps2_clk, ps2_data,
        input  key_press, backspace, key_nibble, nibble_valid, enter_pulse, frame_error
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output key_press, backspace, key_nibble, nibble_valid, enter_pulse, frame_error
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 (scan code set 2) frame receiver plus make/break decoder feeding key_counter.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high
//   bus   : ps2_key_decoder_if.slave (raw PS/2 lines in, key outputs out)
// All outputs are registered.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input logic              clock,
    input logic              reset,
    ps2_key_decoder_if.slave bus
);
    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_NORMAL, DEC_BRK, DEC_EXT, DEC_EXT_BRK} dec_state_t;

    // Returns {is_hex, nibble} for a set-2 make code.
    function automatic logic [4:0] hex_lookup(input logic [7:0] code);
        case (code)
            8'h45:   hex_lookup = 5'h10;
            8'h16:   hex_lookup = 5'h11;
            8'h1E:   hex_lookup = 5'h12;
            8'h26:   hex_lookup = 5'h13;
            8'h25:   hex_lookup = 5'h14;
            8'h2E:   hex_lookup = 5'h15;
            8'h36:   hex_lookup = 5'h16;
            8'h3D:   hex_lookup = 5'h17;
            8'h3E:   hex_lookup = 5'h18;
            8'h46:   hex_lookup = 5'h19;
            8'h1C:   hex_lookup = 5'h1A;
            8'h32:   hex_lookup = 5'h1B;
            8'h21:   hex_lookup = 5'h1C;
            8'h23:   hex_lookup = 5'h1D;
            8'h24:   hex_lookup = 5'h1E;
            8'h2B:   hex_lookup = 5'h1F;
            default: hex_lookup = 5'h00;
        endcase
    endfunction

    // Synchronisers and clock filter
    logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic              data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic              filt_q, filt_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              fall_c;

    // Receiver
    rx_state_t         rx_q, rx_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_ok_q, parity_ok_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              byte_valid_q, byte_valid_d;
    logic [7:0]        byte_q, byte_d;

    // Decoder
    dec_state_t        dec_q, dec_d;
    logic [7:0]        held_code_q, held_code_d;
    logic              enter_held_q, enter_held_d;
    logic              press_pend_q, press_pend_d;
    logic              pend_hex_q, pend_hex_d;
    logic [3:0]        pend_nib_q, pend_nib_d;
    logic              rel_pend_q, rel_pend_d;
    logic [4:0]        hex_c;
    logic              counted_c;

    // Outputs
    logic              key_press_q, key_press_d;
    logic              backspace_q, backspace_d;
    logic [3:0]        key_nibble_q, key_nibble_d;
    logic              nibble_valid_q, nibble_valid_d;
    logic              enter_pulse_q, enter_pulse_d;
    logic              frame_error_q, frame_error_d;

    // Next-state logic for synchroniser, filter, receiver and decoder
    always_comb begin
        clk_s1_d       = bus.ps2_clk;
        clk_s2_d       = clk_s1_q;
        data_s1_d      = bus.ps2_data;
        data_s2_d      = data_s1_q;
        filt_d         = filt_q;
        filt_cnt_d     = filt_cnt_q;
        fall_c         = 1'b0;
        rx_d           = rx_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        parity_ok_d    = parity_ok_q;
        tmo_d          = tmo_q;
        byte_valid_d   = 1'b0;
        byte_d         = byte_q;
        dec_d          = dec_q;
        held_code_d    = held_code_q;
        enter_held_d   = enter_held_q;
        press_pend_d   = press_pend_q;
        pend_hex_d     = pend_hex_q;
        pend_nib_d     = pend_nib_q;
        rel_pend_d     = rel_pend_q;
        key_press_d    = key_press_q;
        backspace_d    = backspace_q;
        key_nibble_d   = key_nibble_q;
        nibble_valid_d = 1'b0;
        enter_pulse_d  = 1'b0;
        frame_error_d  = 1'b0;
        hex_c          = hex_lookup(byte_q);
        counted_c      = hex_c[4] | (byte_q == CODE_BKSP);

        // Filtered clock follows the synchronised clock only after FILTER_LEN disagreeing samples
        if (clk_s2_q == filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
            filt_d     = clk_s2_q;
            filt_cnt_d = '0;
            fall_c     = filt_q;
        end else begin
            filt_cnt_d = filt_cnt_q + FILT_W'(1);
        end

        // Frame receiver; an edge always wins over a simultaneous timeout
        if (fall_c) begin
            tmo_d = '0;
            case (rx_q)
                RX_IDLE: begin
                    if (!data_s2_q) begin
                        rx_d      = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
                RX_DATA: begin
                    shift_d = {data_s2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        rx_d = RX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                RX_PARITY: begin
                    parity_ok_d = ^{shift_q, data_s2_q};
                    rx_d        = RX_STOP;
                end
                RX_STOP: begin
                    if (data_s2_q && parity_ok_q) begin
                        byte_valid_d = 1'b1;
                        byte_d       = shift_q;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                    rx_d = RX_IDLE;
                end
                default: rx_d = RX_IDLE;
            endcase
        end else if (rx_q != RX_IDLE) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                frame_error_d = 1'b1;
                rx_d          = RX_IDLE;
                tmo_d         = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = '0;
        end

        // Deferred halves of make (key_press rise) and break (backspace/held_code clear)
        if (rel_pend_q) begin
            backspace_d = 1'b0;
            held_code_d = 8'h00;
            rel_pend_d  = 1'b0;
        end
        if (press_pend_q) begin
            key_press_d  = 1'b1;
            press_pend_d = 1'b0;
            if (pend_hex_q) begin
                nibble_valid_d = 1'b1;
                key_nibble_d   = pend_nib_q;
            end
        end

        // Make/break decoder
        if (byte_valid_q) begin
            case (dec_q)
                DEC_NORMAL: begin
                    if (byte_q == CODE_BRK) begin
                        dec_d = DEC_BRK;
                    end else if (byte_q == CODE_EXT) begin
                        dec_d = DEC_EXT;
                    end else if (counted_c) begin
                        // held_code of 0 means no key held; 0x00 is never a counted code
                        if (held_code_q == 8'h00) begin
                            held_code_d  = byte_q;
                            backspace_d  = (byte_q == CODE_BKSP);
                            press_pend_d = 1'b1;
                            pend_hex_d   = hex_c[4];
                            pend_nib_d   = hex_c[3:0];
                        end
                    end else if (byte_q == CODE_ENTER && !enter_held_q) begin
                        enter_pulse_d = 1'b1;
                        enter_held_d  = 1'b1;
                    end
                end
                DEC_BRK: begin
                    dec_d = DEC_NORMAL;
                    if (held_code_q != 8'h00 && byte_q == held_code_q && !rel_pend_q) begin
                        key_press_d  = 1'b0;
                        press_pend_d = 1'b0;
                        rel_pend_d   = 1'b1;
                    end
                    if (byte_q == CODE_ENTER) begin
                        enter_held_d = 1'b0;
                    end
                end
                DEC_EXT:     dec_d = (byte_q == CODE_BRK) ? DEC_EXT_BRK : DEC_NORMAL;
                DEC_EXT_BRK: dec_d = DEC_NORMAL;
                default:     dec_d = DEC_NORMAL;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1_q       <= 1'b0;
            clk_s2_q       <= 1'b0;
            data_s1_q      <= 1'b0;
            data_s2_q      <= 1'b0;
            filt_q         <= 1'b0;
            filt_cnt_q     <= '0;
            rx_q           <= RX_IDLE;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'h00;
            parity_ok_q    <= 1'b0;
            tmo_q          <= '0;
            byte_valid_q   <= 1'b0;
            byte_q         <= 8'h00;
            dec_q          <= DEC_NORMAL;
            held_code_q    <= 8'h00;
            enter_held_q   <= 1'b0;
            press_pend_q   <= 1'b0;
            pend_hex_q     <= 1'b0;
            pend_nib_q     <= 4'h0;
            rel_pend_q     <= 1'b0;
            key_press_q    <= 1'b0;
            backspace_q    <= 1'b0;
            key_nibble_q   <= 4'h0;
            nibble_valid_q <= 1'b0;
            enter_pulse_q  <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            clk_s1_q       <= clk_s1_d;
            clk_s2_q       <= clk_s2_d;
            data_s1_q      <= data_s1_d;
            data_s2_q      <= data_s2_d;
            filt_q         <= filt_d;
            filt_cnt_q     <= filt_cnt_d;
            rx_q           <= rx_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            parity_ok_q    <= parity_ok_d;
            tmo_q          <= tmo_d;
            byte_valid_q   <= byte_valid_d;
            byte_q         <= byte_d;
            dec_q          <= dec_d;
            held_code_q    <= held_code_d;
            enter_held_q   <= enter_held_d;
            press_pend_q   <= press_pend_d;
            pend_hex_q     <= pend_hex_d;
            pend_nib_q     <= pend_nib_d;
            rel_pend_q     <= rel_pend_d;
            key_press_q    <= key_press_d;
            backspace_q    <= backspace_d;
            key_nibble_q   <= key_nibble_d;
            nibble_valid_q <= nibble_valid_d;
            enter_pulse_q  <= enter_pulse_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign bus.key_press    = key_press_q;
    assign bus.backspace    = backspace_q;
    assign bus.key_nibble   = key_nibble_q;
    assign bus.nibble_valid = nibble_valid_q;
    assign bus.enter_pulse  = enter_pulse_q;
    assign bus.frame_error  = frame_error_q;
endmodule
